regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, multiply unit) using round-robin arbitration with a valid/ready handshake.
- Drives the register file write port (regWrite, writeAddr, regWriteData) from registers.
- Holds a 32-entry pending-write scoreboard so decode can stall on RAW hazards against writes that are issued but not yet committed.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has a write pending.
- req_addr  input  NUM_REQ*AW  destination register of requester i; requester i uses slice [i*AW +: AW].
- req_data  input  NUM_REQ*DW  write data of requester i; requester i uses slice [i*DW +: DW].
- req_ready  output  NUM_REQ  one-hot grant; the transfer completes when req_valid[i] and req_ready[i] are both high on a rising edge.
- regWrite  output  1  register file write enable (registered).
- writeAddr  output  AW  register file write address (registered).
- regWriteData  output  DW  register file write data (registered).
- issue_valid  input  1  decode is issuing an instruction that writes issue_rd.
- issue_rd  input  AW  destination register of the issuing instruction.
- chk_addr1  input  AW  source register 1 being decoded.
- chk_addr2  input  AW  source register 2 being decoded.
- stall  output  1  RAW hazard on chk_addr1 or chk_addr2.
- pending  output  32  scoreboard bit vector, for debug and verification.

Behaviour:
- Reset (synchronous, active-high) sets:
  - regWrite=0, writeAddr=0, regWriteData=0, pending=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has highest priority in the first cycle after reset.
- Arbitration (combinational):
  - Search order starts at last_grant+1 mod NUM_REQ.
  - The first requester found with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - No valid requester: req_ready=0.
  - req_ready never asserts for a requester whose req_valid is low.
- On an accepted transfer from requester g (rising edge):
  - last_grant<=g.
  - writeAddr<=req_addr[g], regWriteData<=req_data[g].
  - regWrite<=1 if req_addr[g]!=0; if req_addr[g]==0, regWrite<=0 (the write to x0 is consumed and dropped).
- No accepted transfer: regWrite<=0; writeAddr and regWriteData hold their previous values.
- Latency:
  - 1 cycle from acceptance to regWrite high.
  - Sustained throughput is 1 write per cycle.
  - A requester held off keeps valid, address and data stable until it sees ready.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ cycles.
- Scoreboard, updated each rising edge:
  - set_vec: bit issue_rd when issue_valid=1 and issue_rd!=0.
  - clr_vec: bit req_addr[g] when a transfer is accepted and req_addr[g]!=0.
  - pending <= (pending & ~clr_vec) | set_vec. If set and clear hit the same register in one cycle, set wins and the bit stays 1.
  - Bit 0 is always 0.
- Stall (combinational from registered pending only):
  - stall = pending[chk_addr1] | pending[chk_addr2]. Index 0 never stalls.
  - There is no same-cycle bypass: a register cleared this cycle stops stalling on the next cycle.
- Multiple outstanding writes to the same rd are not tracked separately. Decode must not issue a second write to a register whose pending bit is set; this is a checked assertion, not handled by this block.
- Reset mid-operation:
  - In-flight grants are abandoned and the scoreboard is cleared.
  - regWrite is 0 in the cycle after reset is sampled high, even if a write was accepted in the same cycle.
- reset has priority over all other inputs.

Test Plan:
- Reset, then single request: req_valid=001, req_addr0=5, req_data0=0xDEADBEEF -> req_ready=001 that cycle; next cycle regWrite=1, writeAddr=5, regWriteData=0xDEADBEEF; the cycle after, regWrite=0.
- Contention: req_valid=111 held for 6 cycles, addresses 1/2/3 -> grant order 0,1,2,0,1,2; regWrite high for 6 consecutive cycles with writeAddr 1,2,3,1,2,3.
- x0 drop: req_addr1=0, valid -> req_ready[1]=1; regWrite stays 0; pending unchanged.
- Scoreboard hazard:
  - issue_valid=1, issue_rd=7; next cycle chk_addr1=7 -> stall=1, pending[7]=1.
  - Requester 2 writes rd 7 -> stall stays 1 in the accept cycle and drops to 0 the cycle after.
- Simultaneous set/clear: in one cycle, issue_rd=9 and an accepted write to 9 -> pending[9]=1 next cycle. chk_addr2=0 with any pending state -> stall is never caused by index 0.
- Reset mid-stream: req_valid=111 with pending=0x0000_0F00, assert reset for 1 cycle -> next cycle regWrite=0, pending=0; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback sources,
// with a pending-write scoreboard that flags RAW hazards to decode.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 5,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  regWrite,
    output logic [AW-1:0]         writeAddr,
    output logic [DW-1:0]         regWriteData,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic [AW-1:0]         chk_addr1,
    input  logic [AW-1:0]         chk_addr2,
    output logic                  stall,
    output logic [31:0]           pending
);

    localparam int          GW = $clog2(NUM_REQ);
    localparam int unsigned NR = NUM_REQ;

    logic [GW-1:0] lastGrant;
    logic [GW-1:0] grantIdx;
    logic [GW-1:0] candIdx;
    logic          grantValid;
    logic [AW-1:0] grantAddr;
    logic [DW-1:0] grantData;
    logic [31:0]   setVec;
    logic [31:0]   clrVec;
    logic [31:0]   pendingNext;

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        req_ready  = '0;
        grantIdx   = lastGrant;
        grantValid = 1'b0;
        candIdx    = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            candIdx = GW'((32'(lastGrant) + k) % NR);
            if (!grantValid && req_valid[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
        if (grantValid) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign grantAddr = req_addr[grantIdx*AW +: AW];
    assign grantData = req_data[grantIdx*DW +: DW];

    always_comb begin
        setVec = '0;
        clrVec = '0;
        if (issue_valid && issue_rd != '0) begin
            setVec[issue_rd] = 1'b1;
        end
        if (grantValid && grantAddr != '0) begin
            clrVec[grantAddr] = 1'b1;
        end
        // Set is applied after clear so a same-cycle issue keeps the bit.
        pendingNext    = (pending & ~clrVec) | setVec;
        pendingNext[0] = 1'b0;
    end

    assign stall = pending[chk_addr1] | pending[chk_addr2];

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant    <= GW'(NUM_REQ - 1);
            regWrite     <= 1'b0;
            writeAddr    <= '0;
            regWriteData <= '0;
            pending      <= '0;
        end else begin
            if (grantValid) begin
                lastGrant    <= grantIdx;
                writeAddr    <= grantAddr;
                regWriteData <= grantData;
                regWrite     <= (grantAddr != '0);
            end else begin
                regWrite <= 1'b0;
            end
            pending <= pendingNext;
        end
    end

    // Decode must not issue a second outstanding write to the same register.
    noDoubleIssue: assert property (@(posedge clk) disable iff (reset)
        (issue_valid && issue_rd != '0) |-> !pending[issue_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: driver pushes model expectations per cycle, monitor pops and compares.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] regWriteData;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        stall;
    logic [31:0] pending;

    regfile_wb_arbiter #(.NUM_REQ(3), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .regWrite(regWrite), .writeAddr(writeAddr), .regWriteData(regWriteData),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .stall(stall), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  ready;
        logic        stall;
        logic [31:0] pend;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycNum = 0;
    bit   done   = 0;

    // Reference state: what the write port and scoreboard must hold this cycle.
    int        mLast;
    bit [31:0] mPend;
    bit        mRw;
    bit [4:0]  mWa;
    bit [31:0] mWd;

    task automatic modelReset();
        mLast = 2;
        mPend = '0;
        mRw   = 0;
        mWa   = '0;
        mWd   = '0;
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit [2:0] v,
                        input bit [4:0] a0, input bit [4:0] a1, input bit [4:0] a2,
                        input bit [31:0] d0, input bit [31:0] d1, input bit [31:0] d2,
                        input bit iv, input bit [4:0] ird,
                        input bit [4:0] c1, input bit [4:0] c2, output int g);
        bit [4:0]  a[3];
        bit [31:0] d[3];
        exp_t      e;
        int        j;
        a[0] = a0; a[1] = a1; a[2] = a2;
        d[0] = d0; d[1] = d1; d[2] = d2;
        reset       = rst;
        req_valid   = v;
        req_addr    = {a2, a1, a0};
        req_data    = {d2, d1, d0};
        issue_valid = iv;
        issue_rd    = ird;
        chk_addr1   = c1;
        chk_addr2   = c2;

        g = -1;
        for (int k = 1; k <= 3; k++) begin
            j = (mLast + k) % 3;
            if (g < 0 && v[j]) g = j;
        end
        e.cyc   = cycNum;
        e.ready = (g >= 0) ? (3'b001 << g) : 3'b000;
        e.stall = (c1 != 0 && mPend[c1]) || (c2 != 0 && mPend[c2]);
        e.pend  = mPend;
        e.rw    = mRw;
        e.wa    = mWa;
        e.wd    = mWd;
        expQ.push_back(e);

        if (rst) begin
            modelReset();
        end else begin
            if (g >= 0) begin
                mLast = g;
                mWa   = a[g];
                mWd   = d[g];
                mRw   = (a[g] != 0);
                if (a[g] != 0) mPend[a[g]] = 0;
            end else begin
                mRw = 0;
            end
            if (iv && ird != 0) mPend[ird] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cycNum <= cycNum + 1;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("req_ready", e.cyc, 32'(req_ready), 32'(e.ready));
                chk("stall", e.cyc, 32'(stall), 32'(e.stall));
                chk("pending", e.cyc, pending, e.pend);
                chk("regWrite", e.cyc, 32'(regWrite), 32'(e.rw));
                chk("writeAddr", e.cyc, 32'(writeAddr), 32'(e.wa));
                chk("regWriteData", e.cyc, regWriteData, e.wd);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int        g;
        bit        hv[3];
        bit [4:0]  ha[3];
        bit [31:0] hd[3];
        bit [4:0]  rd;
        bit        iv;
        bit        rst;

        reset = 1; req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 0; issue_rd = '0; chk_addr1 = '0; chk_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        // Single request, then two idle cycles to see the write and its release.
        step(0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Contention from a fresh reset: grants rotate 0,1,2,0,1,2.
        step(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        for (int i = 0; i < 6; i++)
            step(0, 3'b111, 1, 2, 3, $urandom, $urandom, $urandom, 0, 0, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Write to x0 is granted but dropped.
        step(0, 3'b010, 0, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // RAW hazard on x7, cleared by requester 2.
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, g);
        step(0, 3'b100, 0, 0, 7, 0, 0, 32'hCAFE_0007, 0, 0, 7, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, g);

        // Same-cycle set and clear of x9; then index 0 must never stall.
        step(0, 3'b001, 9, 0, 0, 32'h0000_0009, 0, 0, 1, 9, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Build pending = 0xF00, then reset mid-stream with all requesters valid.
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 11, 8, 0, g);
        step(1, 3'b111, 4, 5, 6, 32'hA, 32'hB, 32'hC, 0, 0, 8, 11, g);
        step(0, 3'b111, 4, 5, 6, 32'hA, 32'hB, 32'hC, 0, 0, 8, 11, g);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Random traffic: requesters hold their request until granted.
        for (int i = 0; i < 3; i++) hv[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!hv[i] && $urandom_range(0, 99) < 55) begin
                    hv[i] = 1;
                    ha[i] = 5'($urandom_range(0, 31));
                    hd[i] = $urandom;
                end
            end
            rd  = 5'($urandom_range(0, 31));
            iv  = ($urandom_range(0, 1) == 1) && !mPend[rd];
            rst = ($urandom_range(0, 63) == 0);
            step(rst, {hv[2], hv[1], hv[0]}, ha[0], ha[1], ha[2], hd[0], hd[1], hd[2],
                 iv, rd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), g);
            if (g >= 0) hv[g] = 0;
        end
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        done = 1;
    end

    initial begin : finisher
        wait (done);
        @(negedge clk);
        @(negedge clk);
        chk("drained", cycNum, 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
